// File: rtl/sseg_scan_ctrl.sv
// Memory-mapped 4-digit seven-segment scan controller with DATA/CTRL registers,
// frame-aligned shadowing, anti-ghost blanking, leading-zero blanking and dp mask.
module sseg_scan_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h1100C010,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 2
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] rd_data,
  output logic [7:0]  segs,
  output logic [3:0]  an
);

  localparam int unsigned     CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [31:0]     CTRL_ADDR = BASE_ADDR + 32'd4;
  localparam logic [CNT_W-1:0] CNT_TC    = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  logic [15:0]      data_q, data_d;
  logic [7:0]       ctrl_q, ctrl_d;
  logic [15:0]      sh_data_q, sh_data_d;
  logic [7:0]       sh_ctrl_q, sh_ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       segs_q, segs_d;

  logic       data_wr_c, ctrl_wr_c, run_c, wrap_c, lz_blank_c;
  logic [3:0] nib_c;
  logic [3:0] dp_mask_c;
  logic       unused_ok_c;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  assign unused_ok_c = ^{IOBUS_OUT[31:16], sh_ctrl_q[3:2]};

  always_comb begin
    rd_data = 32'h0;
    if (IOBUS_ADDR == BASE_ADDR)      rd_data = {16'h0, data_q};
    else if (IOBUS_ADDR == CTRL_ADDR) rd_data = {24'h0, ctrl_q};
  end

  always_comb begin
    data_d    = data_q;
    ctrl_d    = ctrl_q;
    sh_data_d = sh_data_q;
    sh_ctrl_d = sh_ctrl_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    an_d      = 4'hF;
    segs_d    = 8'hFF;

    data_wr_c = IOBUS_WR && (IOBUS_ADDR == BASE_ADDR);
    ctrl_wr_c = IOBUS_WR && (IOBUS_ADDR == CTRL_ADDR) && !data_wr_c;
    if (data_wr_c) data_d = IOBUS_OUT[15:0];
    if (ctrl_wr_c) ctrl_d = IOBUS_OUT[7:0];

    // Clearing CTRL enable stops the scan at once; everything else waits for the frame wrap
    run_c  = sh_ctrl_q[0] && ctrl_q[0];
    wrap_c = run_c && (cnt_q == CNT_TC) && (idx_q == 2'd3);

    // Shadows take the register values before any write landing on this edge
    if (wrap_c || !run_c) begin
      sh_data_d = data_q;
      sh_ctrl_d = ctrl_q;
    end

    if (!run_c) begin
      cnt_d = '0;
      idx_d = 2'd0;
    end else if (cnt_q == CNT_TC) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    nib_c      = sh_data_q[{idx_q, 2'b00} +: 4];
    dp_mask_c  = sh_ctrl_q[7:4];
    lz_blank_c = sh_ctrl_q[1] && (idx_q != 2'd0) &&
                 ((sh_data_q >> {idx_q, 2'b00}) == 16'h0);

    if (run_c && (cnt_q >= CNT_BLANK) && !lz_blank_c) begin
      an_d   = ~(4'b0001 << idx_q);
      segs_d = {~dp_mask_c[idx_q], hex_glyph(nib_c)};
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      data_q    <= 16'h0;
      ctrl_q    <= 8'h01;
      sh_data_q <= 16'h0;
      sh_ctrl_q <= 8'h01;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      an_q      <= 4'hF;
      segs_q    <= 8'hFF;
    end else begin
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      sh_data_q <= sh_data_d;
      sh_ctrl_q <= sh_ctrl_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      segs_q    <= segs_d;
    end
  end

  assign an   = an_q;
  assign segs = segs_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with REFRESH_DIV=8, BLANK_CYC=2 (32-cycle frames).
module tb_sseg_scan_ctrl;

  localparam logic [31:0] BASE   = 32'h1100C010;
  localparam logic [31:0] CTRL_A = 32'h1100C014;
  localparam logic [31:0] UNMAP  = 32'h1100C018;
  localparam logic [11:0] DARK   = 12'hFFF;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] IOBUS_ADDR = 32'h0;
  logic [31:0] IOBUS_OUT = 32'h0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] rd_data;
  logic [7:0]  segs;
  logic [3:0]  an;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.BASE_ADDR(BASE), .REFRESH_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .RESET(RESET), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .rd_data(rd_data), .segs(segs), .an(an)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) step();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    step();
    IOBUS_WR   = 1'b0;
  endtask

  task automatic do_reset();
    IOBUS_WR = 1'b0;
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    RESET = 1'b1;
    IOBUS_ADDR = BASE; IOBUS_OUT = 32'hFFFF; IOBUS_WR = 1'b1;
    step();
    step();
    n_vec++;
    if ({an, segs} !== DARK) begin
      n_err++;
      $display("FAIL reset_pins: got an=%h segs=%h, expected an=f segs=ff", an, segs);
    end
    RESET = 1'b0; IOBUS_WR = 1'b0;
    #1;
    n_vec++;
    if (rd_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data_rd: got %h, expected 00000000", rd_data);
    end
    IOBUS_ADDR = CTRL_A;
    #1;
    n_vec++;
    if (rd_data !== 32'h1) begin
      n_err++;
      $display("FAIL reset_ctrl_rd: got %h, expected 00000001", rd_data);
    end
    for (int n = 1; n <= 3; n++) begin
      step();
      exp = (n < 3) ? DARK : 12'hEC0;
      n_vec++;
      if ({an, segs} !== exp) begin
        n_err++;
        $display("FAIL reset_release step %0d: got %h, expected %h", n, {an, segs}, exp);
      end
    end
  endtask

  task automatic test_scan();
    logic [11:0] lit [4];
    logic [11:0] exp;
    lit = '{12'hE8E, 12'hDB0, 12'hB88, 12'h7F9};
    do_reset();
    bus_write(BASE, 32'h1A3F);
    idle(30);
    step();
    n_vec++;
    if ({an, segs} !== 12'h7C0) begin
      n_err++;
      $display("FAIL scan_old_frame: got %h, expected 7c0", {an, segs});
    end
    for (int i = 0; i < 32; i++) begin
      step();
      exp = (i % 8 < 2) ? DARK : lit[i / 8];
      n_vec++;
      if ({an, segs} !== exp) begin
        n_err++;
        $display("FAIL scan slot %0d: got %h, expected %h", i, {an, segs}, exp);
      end
    end
  endtask

  task automatic test_lzb();
    logic [11:0] exp;
    do_reset();
    bus_write(BASE, 32'h0005);
    bus_write(CTRL_A, 32'h03);
    idle(30);
    for (int i = 0; i < 32; i++) begin
      step();
      exp = (i % 8 < 2 || i >= 8) ? DARK : 12'hE92;
      n_vec++;
      if ({an, segs} !== exp) begin
        n_err++;
        $display("FAIL lzb_five slot %0d: got %h, expected %h", i, {an, segs}, exp);
      end
    end
    bus_write(BASE, 32'h0000);
    idle(31);
    for (int i = 0; i < 32; i++) begin
      step();
      exp = (i % 8 < 2 || i >= 8) ? DARK : 12'hEC0;
      n_vec++;
      if ({an, segs} !== exp) begin
        n_err++;
        $display("FAIL lzb_zero slot %0d: got %h, expected %h", i, {an, segs}, exp);
      end
    end
  endtask

  task automatic test_dp_readback();
    logic [11:0] lit [4];
    logic [11:0] exp;
    lit = '{12'hE00, 12'hD80, 12'hB00, 12'h780};
    do_reset();
    bus_write(CTRL_A, 32'hFFFF_FF51);
    bus_write(BASE, 32'hABCD_8888);
    IOBUS_ADDR = CTRL_A;
    #1;
    n_vec++;
    if (rd_data !== 32'h51) begin
      n_err++;
      $display("FAIL rd_ctrl: got %h, expected 00000051", rd_data);
    end
    IOBUS_ADDR = BASE;
    #1;
    n_vec++;
    if (rd_data !== 32'h8888) begin
      n_err++;
      $display("FAIL rd_data: got %h, expected 00008888", rd_data);
    end
    IOBUS_ADDR = UNMAP;
    #1;
    n_vec++;
    if (rd_data !== 32'h0) begin
      n_err++;
      $display("FAIL rd_unmapped: got %h, expected 00000000", rd_data);
    end
    idle(30);
    for (int i = 0; i < 32; i++) begin
      step();
      exp = (i % 8 < 2) ? DARK : lit[i / 8];
      n_vec++;
      if ({an, segs} !== exp) begin
        n_err++;
        $display("FAIL dp slot %0d: got %h, expected %h", i, {an, segs}, exp);
      end
    end
  endtask

  task automatic test_tear();
    logic [11:0] old_lit [4];
    logic [11:0] new_lit [4];
    logic [11:0] exp;
    old_lit = '{12'hE8E, 12'hDB0, 12'hB88, 12'h7F9};
    new_lit = '{12'hE80, 12'hD80, 12'hB80, 12'h780};
    do_reset();
    bus_write(BASE, 32'h1A3F);
    idle(30);
    bus_write(BASE, 32'h0005);
    for (int i = 0; i < 32; i++) begin
      if (i == 11) begin
        IOBUS_ADDR = BASE; IOBUS_OUT = 32'h8888; IOBUS_WR = 1'b1;
      end
      step();
      IOBUS_WR = 1'b0;
      exp = (i % 8 < 2) ? DARK : old_lit[i / 8];
      n_vec++;
      if ({an, segs} !== exp) begin
        n_err++;
        $display("FAIL tear_old slot %0d: got %h, expected %h", i, {an, segs}, exp);
      end
    end
    for (int i = 0; i < 32; i++) begin
      step();
      exp = (i % 8 < 2) ? DARK : new_lit[i / 8];
      n_vec++;
      if ({an, segs} !== exp) begin
        n_err++;
        $display("FAIL tear_new slot %0d: got %h, expected %h", i, {an, segs}, exp);
      end
    end
  endtask

  task automatic test_disable_reset();
    logic [11:0] exp;
    do_reset();
    idle(5);
    bus_write(CTRL_A, 32'h00);
    n_vec++;
    if ({an, segs} !== 12'hEC0) begin
      n_err++;
      $display("FAIL disable_write_edge: got %h, expected ec0", {an, segs});
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if ({an, segs} !== DARK) begin
        n_err++;
        $display("FAIL disabled cycle %0d: got %h, expected fff", i, {an, segs});
      end
    end
    bus_write(CTRL_A, 32'h01);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      exp = (i < 4) ? DARK : 12'hEC0;
      n_vec++;
      if ({an, segs} !== exp) begin
        n_err++;
        $display("FAIL reenable cycle %0d: got %h, expected %h", i, {an, segs}, exp);
      end
    end
    idle(15);
    step();
    n_vec++;
    if ({an, segs} !== 12'hBC0) begin
      n_err++;
      $display("FAIL index2_lit: got %h, expected bc0", {an, segs});
    end
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    n_vec++;
    if ({an, segs} !== DARK) begin
      n_err++;
      $display("FAIL midscan_reset: got %h, expected fff", {an, segs});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      exp = (i < 2) ? DARK : 12'hEC0;
      n_vec++;
      if ({an, segs} !== exp) begin
        n_err++;
        $display("FAIL resume cycle %0d: got %h, expected %h", i, {an, segs}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lzb();
    test_dp_readback();
    test_tear();
    test_disable_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
